// File: rtl/csa_bist_pkg.sv
// Shared types, constants and the golden cell model for the conditional-sum
// adder self-test and reconfiguration controller.
package csa_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DECIDE = 3'd4
    } bist_state_e;

    localparam int NUM_CELLS = 5;   // observable physical cells 0..4
    localparam int NUM_POS   = 4;   // logical positions L0..L3
    localparam int CELL_W    = 6;   // response width of one cell

    // Fault-free mapping: logical 0,1,2,3 -> physical cells 0,1,2,4
    localparam logic [2:0] DEFAULT_IS0 = 3'b000;
    localparam logic [2:0] DEFAULT_IS1 = 3'b000;
    localparam logic [3:0] DEFAULT_SS0 = 4'b1000;
    localparam logic [3:0] DEFAULT_SS1 = 4'b0000;

    // Legal physical cells for each logical position form a contiguous range
    localparam int LEGAL_LO [NUM_POS] = '{0, 1, 2, 4};
    localparam int LEGAL_HI [NUM_POS] = '{2, 3, 4, 5};

    // Expected test-mode response of one conditional-sum cell, pattern {x1,y1,x0,y0}
    function automatic logic [5:0] golden_csc(input logic [3:0] pat);
        logic x1, y1, x0, y0;
        logic a1, a0, p1, p0;
        logic b1, b0, q1, q0;
        logic c11, c10, s11, s10;
        {x1, y1, x0, y0} = pat;
        a1 = x0 ^ y0;
        a0 = ~(x0 | y0);
        p1 = ~(x0 ^ y0);
        p0 = x0 ^ y0;
        b1 = x1 ^ y1;
        b0 = ~(x1 | y1);
        q1 = ~(x1 ^ y1);
        q0 = x1 ^ y1;
        {c11, s11} = a1 ? {b1, q1} : {b0, q0};
        {c10, s10} = a0 ? {b1, q1} : {b0, q0};
        return {c11, c10, s11, s10, p1, p0};
    endfunction

endpackage

// File: rtl/csa_reconfig_map.sv
// Combinational fault map -> adder select controls. Each logical position is
// placed greedily on the lowest healthy legal cell above the previous one.
module csa_reconfig_map
    import csa_bist_pkg::*;
(
    input  logic [4:0] fault_map,
    output logic [2:0] is0,
    output logic [2:0] is1,
    output logic [3:0] ss0,
    output logic [3:0] ss1,
    output logic       uncorrectable
);

    // Cell 5 cannot be observed, so it is always treated as healthy
    logic [5:0] healthy;
    int         host [NUM_POS];
    genvar      gi;

    assign healthy = {1'b1, ~fault_map};

    // Greedy placement of logical positions onto physical cells
    always_comb begin : greedy_place
        int   prev;
        logic found;
        prev          = -1;
        found         = 1'b0;
        uncorrectable = 1'b0;
        for (int k = 0; k < NUM_POS; k++) begin
            host[k] = prev;
            found   = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (!found && c >= LEGAL_LO[k] && c <= LEGAL_HI[k] &&
                    c > prev && healthy[3'(c)]) begin
                    host[k] = c;
                    found   = 1'b1;
                end
            end
            if (!found) begin
                uncorrectable = 1'b1;
            end else begin
                prev = host[k];
            end
        end
    end

    // Input steering: a cell hosting a lower logical position takes its operands
    assign is0 = {host[2] == 4, (host[1] == 2) || (host[1] == 3), (host[0] == 1) || (host[0] == 2)};
    assign is1 = {host[2] == 4, host[1] == 3, host[0] == 2};

    // Output steering: shift by one sets ss0[k]; shift by two sets ss1[k] and ss0[k+1]
    generate
        for (gi = 0; gi < NUM_POS; gi++) begin : g_ss
            if (gi == 0) begin : g_first
                assign ss0[gi] = (host[gi] == gi + 1);
            end else begin : g_rest
                assign ss0[gi] = (host[gi] == gi + 1) || (host[gi-1] == gi + 1);
            end
            assign ss1[gi] = (host[gi] == gi + 2);
        end
    endgenerate

endmodule

// File: rtl/csa_bist_ctrl.sv
// Self-test sequencer: applies every 4-bit pattern to cells 0..4, accumulates a
// fault map and, when repairable, registers a new adder configuration.
module csa_bist_ctrl
    import csa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_VEC       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] actual_output,
    output logic        test,
    output logic [3:0]  test_data,
    output logic [2:0]  is0,
    output logic [2:0]  is1,
    output logic [3:0]  ss0,
    output logic [3:0]  ss1,
    output logic        busy,
    output logic        done,
    output logic [4:0]  fault_map,
    output logic        uncorrectable
);

    bist_state_e state_reg, state_next;
    logic [3:0]  vec_reg, vec_next;
    logic [2:0]  settle_reg, settle_next;
    logic [4:0]  fault_work_reg, fault_work_next;
    logic [4:0]  fault_map_reg, fault_map_next;
    logic        unc_reg, unc_next;
    logic [2:0]  is0_reg, is0_next, is1_reg, is1_next;
    logic [3:0]  ss0_reg, ss0_next, ss1_reg, ss1_next;

    logic [5:0]  golden_now;
    logic [4:0]  mismatch;
    logic [2:0]  map_is0, map_is1;
    logic [3:0]  map_ss0, map_ss1;
    logic        map_unc;
    genvar       gi;

    assign golden_now = golden_csc(vec_reg);

    // One comparator per observable cell against the golden response
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cmp
            assign mismatch[gi] = (actual_output[CELL_W*gi +: CELL_W] != golden_now);
        end
    endgenerate

    csa_reconfig_map u_map (
        .fault_map     (fault_work_reg),
        .is0           (map_is0),
        .is1           (map_is1),
        .ss0           (map_ss0),
        .ss1           (map_ss1),
        .uncorrectable (map_unc)
    );

    // State and result registers; reset also restores the fault-free config
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            vec_reg        <= 4'd0;
            settle_reg     <= 3'd0;
            fault_work_reg <= 5'd0;
            fault_map_reg  <= 5'd0;
            unc_reg        <= 1'b0;
            is0_reg        <= DEFAULT_IS0;
            is1_reg        <= DEFAULT_IS1;
            ss0_reg        <= DEFAULT_SS0;
            ss1_reg        <= DEFAULT_SS1;
        end else begin
            state_reg      <= state_next;
            vec_reg        <= vec_next;
            settle_reg     <= settle_next;
            fault_work_reg <= fault_work_next;
            fault_map_reg  <= fault_map_next;
            unc_reg        <= unc_next;
            is0_reg        <= is0_next;
            is1_reg        <= is1_next;
            ss0_reg        <= ss0_next;
            ss1_reg        <= ss1_next;
        end
    end

    // Next-state sequencing and state-decoded outputs
    always_comb begin
        state_next      = state_reg;
        vec_next        = vec_reg;
        settle_next     = settle_reg;
        fault_work_next = fault_work_reg;
        fault_map_next  = fault_map_reg;
        unc_next        = unc_reg;
        is0_next        = is0_reg;
        is1_next        = is1_reg;
        ss0_next        = ss0_reg;
        ss1_next        = ss1_reg;
        test            = 1'b0;
        test_data       = 4'd0;
        done            = 1'b0;
        busy            = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next      = ST_APPLY;
                    vec_next        = 4'd0;
                    fault_work_next = 5'd0;
                end
            end
            ST_APPLY: begin
                test        = 1'b1;
                test_data   = vec_reg;
                settle_next = 3'd1;
                state_next  = (SETTLE_CYCLES == 1) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                test      = 1'b1;
                test_data = vec_reg;
                if (settle_reg == 3'(SETTLE_CYCLES - 1)) begin
                    state_next = ST_CHECK;
                end else begin
                    settle_next = settle_reg + 3'd1;
                end
            end
            ST_CHECK: begin
                test            = 1'b1;
                test_data       = vec_reg;
                fault_work_next = fault_work_reg | mismatch;
                if (vec_reg == 4'(NUM_VEC - 1)) begin
                    state_next = ST_DECIDE;
                end else begin
                    vec_next   = vec_reg + 4'd1;
                    state_next = ST_APPLY;
                end
            end
            ST_DECIDE: begin
                done           = 1'b1;
                fault_map_next = fault_work_reg;
                unc_next       = map_unc;
                if (!map_unc) begin
                    is0_next = map_is0;
                    is1_next = map_is1;
                    ss0_next = map_ss0;
                    ss1_next = map_ss1;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fault_map     = fault_map_reg;
    assign uncorrectable = unc_reg;
    assign is0           = is0_reg;
    assign is1           = is1_reg;
    assign ss0           = ss0_reg;
    assign ss1           = ss1_reg;

endmodule

// File: tb/tb_csa_bist_ctrl.sv
// Bench for csa_bist_ctrl: a behavioural adder with injectable faults, a
// cycle-level expectation model, and directed runs with literal expectations.
module tb_csa_bist_ctrl;

    localparam int S      = 1;
    localparam int NV     = 16;
    localparam int P      = S + 1;
    localparam int DONE_N = NV * P + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [29:0] actual_output;
    logic        test;
    logic [3:0]  test_data;
    logic [2:0]  is0, is1;
    logic [3:0]  ss0, ss1;
    logic        busy, done;
    logic [4:0]  fault_map;
    logic        uncorrectable;

    logic [29:0] stuck0_mask = 30'd0;
    logic [29:0] flip_mask   = 30'd0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_bist_ctrl #(.SETTLE_CYCLES(S), .NUM_VEC(NV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .actual_output (actual_output),
        .test          (test),
        .test_data     (test_data),
        .is0           (is0),
        .is1           (is1),
        .ss0           (ss0),
        .ss1           (ss1),
        .busy          (busy),
        .done          (done),
        .fault_map     (fault_map),
        .uncorrectable (uncorrectable)
    );

    // Reference cell: low pair selects which precomputed high-pair result is used
    function automatic logic [5:0] ref_cell(input logic [3:0] pat);
        logic lo_x, lo_n, hi_x, hi_n;
        logic [1:0] hi_ci1, hi_ci0, r1, r0;
        lo_x   = pat[1] ^ pat[0];
        lo_n   = !(pat[1] || pat[0]);
        hi_x   = pat[3] ^ pat[2];
        hi_n   = !(pat[3] || pat[2]);
        hi_ci1 = {hi_x, !hi_x};
        hi_ci0 = {hi_n, hi_x};
        r1     = lo_x ? hi_ci1 : hi_ci0;
        r0     = lo_n ? hi_ci1 : hi_ci0;
        return {r1[1], r0[1], r1[0], r0[0], !lo_x, lo_x};
    endfunction

    function automatic logic [29:0] adder_resp(input logic [3:0] pat, input logic [29:0] s0m,
                                               input logic [29:0] flm);
        logic [29:0] r;
        r = {5{ref_cell(pat)}};
        return (r & ~s0m) ^ flm;
    endfunction

    // Faulty cells = any cell whose response differs from golden on some pattern
    function automatic logic [4:0] faults_of(input logic [29:0] s0m, input logic [29:0] flm);
        logic [4:0]  f;
        logic [29:0] r;
        logic [5:0]  g;
        f = 5'd0;
        for (int v = 0; v < NV; v++) begin
            r = adder_resp(4'(v), s0m, flm);
            g = ref_cell(4'(v));
            for (int i = 0; i < 5; i++)
                if (r[6*i +: 6] != g) f[3'(i)] = 1'b1;
        end
        return f;
    endfunction

    // Placement model: walk positions, take the first usable healthy cell
    task automatic model_map(input logic [4:0] f, output logic [2:0] m_is0, output logic [2:0] m_is1,
                             output logic [3:0] m_ss0, output logic [3:0] m_ss1, output logic m_unc);
        int lo [4] = '{0, 1, 2, 4};
        int hi [4] = '{2, 3, 4, 5};
        logic [5:0] ok;
        int host, prev, d;
        ok = {1'b1, ~f};
        prev = -1;
        m_unc = 1'b0;
        m_is0 = 3'd0; m_is1 = 3'd0; m_ss0 = 4'd0; m_ss1 = 4'd0;
        for (int k = 0; k < 4; k++) begin
            host = -1;
            for (int c = (lo[k] > prev + 1) ? lo[k] : prev + 1; c <= hi[k] && host < 0; c++)
                if (ok[3'(c)]) host = c;
            if (host < 0) begin
                m_unc = 1'b1;
            end else begin
                prev = host;
                d = host - k;
                if (d == 1) begin
                    m_ss0[2'(k)] = 1'b1;
                    if (k < 2) m_is0[2'(k)] = 1'b1;
                end
                if (d == 2) begin
                    m_ss1[2'(k)] = 1'b1;
                    if (k < 3) begin
                        m_ss0[2'(k + 1)] = 1'b1;
                        m_is0[2'(k)] = 1'b1;
                        m_is1[2'(k)] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always_comb actual_output = adder_resp(test_data, stuck0_mask, flip_mask);

    // Cycle model and per-cycle comparison
    bit         model_valid = 1'b0;
    bit         running = 1'b0;
    int         t0 = 0;
    logic [4:0] m_run_faults = 5'd0, m_fmap = 5'd0;
    logic       m_unc = 1'b0;
    logic [2:0] m_is0 = 3'b000, m_is1 = 3'b000;
    logic [3:0] m_ss0 = 4'b1000, m_ss1 = 4'b0000;

    always @(negedge clk) begin
        int n;
        bit e_test, e_busy, e_done, was_running;
        logic [3:0] e_td;
        logic [2:0] n_is0, n_is1;
        logic [3:0] n_ss0, n_ss1;
        logic n_unc;
        n = running ? cyc - t0 : 0;
        if (model_valid) begin
            e_test = running && n >= 1 && n <= NV * P;
            e_td   = e_test ? 4'((n - 1) / P) : 4'd0;
            e_busy = running && n >= 1;
            e_done = running && n == DONE_N;
            chk("cyc_test", test, e_test);
            chk("cyc_test_data", test_data, e_td);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_done", done, e_done);
            chk("cyc_fault_map", fault_map, m_fmap);
            chk("cyc_uncorrectable", uncorrectable, m_unc);
            chk("cyc_is0", is0, m_is0);
            chk("cyc_is1", is1, m_is1);
            chk("cyc_ss0", ss0, m_ss0);
            chk("cyc_ss1", ss1, m_ss1);
        end
        if (!rst_n) begin
            model_valid = 1'b1;
            running = 1'b0;
            m_fmap = 5'd0; m_unc = 1'b0;
            m_is0 = 3'b000; m_is1 = 3'b000; m_ss0 = 4'b1000; m_ss1 = 4'b0000;
        end else if (model_valid) begin
            was_running = running;
            if (running && n == DONE_N) begin
                running = 1'b0;
                m_fmap = m_run_faults;
                model_map(m_run_faults, n_is0, n_is1, n_ss0, n_ss1, n_unc);
                m_unc = n_unc;
                if (!n_unc) begin
                    m_is0 = n_is0; m_is1 = n_is1; m_ss0 = n_ss0; m_ss1 = n_ss1;
                end
            end
            if (!was_running && start) begin
                running = 1'b1;
                t0 = cyc;
                m_run_faults = faults_of(stuck0_mask, flip_mask);
            end
        end
    end

    task automatic chk_cfg(input string tag, input logic [4:0] fm, input logic unc,
                           input logic [2:0] e0, input logic [2:0] e1,
                           input logic [3:0] f0, input logic [3:0] f1);
        chk({tag, "_fault_map"}, fault_map, fm);
        chk({tag, "_unc"}, uncorrectable, unc);
        chk({tag, "_is0"}, is0, e0);
        chk({tag, "_is1"}, is1, e1);
        chk({tag, "_ss0"}, ss0, f0);
        chk({tag, "_ss1"}, ss1, f1);
    endtask

    // One complete self-test; optionally pokes start again while busy
    task automatic do_run(input string tag, input bit poke);
        int ts, lat;
        @(posedge clk); #1 start = 1'b1; ts = cyc;
        @(posedge clk); #1 start = 1'b0;
        if (poke) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - ts;
                break;
            end
        end
        chk({tag, "_done_latency"}, lat, DONE_N);
        @(posedge clk); #1;
        $display("run %s: latency=%0d fault_map=%b unc=%b is0=%b is1=%b ss0=%b ss1=%b",
                 tag, lat, fault_map, uncorrectable, is0, is1, ss0, ss1);
    endtask

    initial begin
        logic [2:0] p_is0, p_is1;
        logic [3:0] p_ss0, p_ss1;
        logic p_unc;
        int ts, dn;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_test", test, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk_cfg("reset", 5'b00000, 1'b0, 3'b000, 3'b000, 4'b1000, 4'b0000);
        $display("reset idle: test=%b busy=%b ss0=%b", test, busy, ss0);

        // Pin the bench's own golden and placement models to hand values
        chk("golden_p0", ref_cell(4'd0), 6'h26);
        chk("golden_p5", ref_cell(4'd5), 6'h25);
        model_map(5'b11100, p_is0, p_is1, p_ss0, p_ss1, p_unc);
        chk("model_unc_234", p_unc, 1'b1);
        model_map(5'b00011, p_is0, p_is1, p_ss0, p_ss1, p_unc);
        chk("model_ss1_01", p_ss1, 4'b1111);

        // Healthy adder
        do_run("healthy", 1'b0);
        chk_cfg("healthy", 5'b00000, 1'b0, 3'b000, 3'b000, 4'b1000, 4'b0000);

        // Cell 1 output bit 5 stuck at 0
        stuck0_mask = 30'd1 << 11;
        do_run("cell1_sa0", 1'b0);
        chk_cfg("cell1_sa0", 5'b00010, 1'b0, 3'b010, 3'b000, 4'b1110, 4'b0000);
        stuck0_mask = 30'd0;

        // Cells 0 and 1 faulty
        flip_mask = (30'd1 << 0) | (30'd1 << 6);
        do_run("cells01", 1'b0);
        chk_cfg("cells01", 5'b00011, 1'b0, 3'b111, 3'b111, 4'b1110, 4'b1111);

        // Cells 3 and 4 faulty
        flip_mask = (30'd1 << 18) | (30'd1 << 24);
        do_run("cells34", 1'b0);
        chk_cfg("cells34", 5'b11000, 1'b0, 3'b000, 3'b000, 4'b0000, 4'b1000);

        // Cells 2, 3, 4 faulty: not repairable, previous config kept
        flip_mask = (30'd1 << 12) | (30'd1 << 18) | (30'd1 << 24);
        do_run("cells234", 1'b0);
        chk_cfg("cells234", 5'b11100, 1'b1, 3'b000, 3'b000, 4'b0000, 4'b1000);

        // Reset at cycle 10 of a run
        flip_mask = 30'd1 << 6;
        @(posedge clk); #1 start = 1'b1; ts = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("midreset_test", test, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk_cfg("midreset", 5'b00000, 1'b0, 3'b000, 3'b000, 4'b1000, 4'b0000);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("midreset_no_done", dn, 0);
        $display("run midreset: reset at cycle %0d of run, done pulses after=%0d", cyc - ts - 40, dn);

        // Healthy again, with a start poked while busy
        flip_mask = 30'd0;
        do_run("healthy_poke", 1'b1);
        chk_cfg("healthy_poke", 5'b00000, 1'b0, 3'b000, 3'b000, 4'b1000, 4'b0000);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/csa_bist_ctrl.md
Name: csa_bist_ctrl

Overview:
Built-in self-test and reconfiguration controller for the 7-bit double-fault-tolerant conditional-sum adder. On request it puts the adder in test mode and applies all 16 four-bit test patterns to physical conditional-sum cells 0..4. It compares each cell's 6-bit response against a golden model and builds a fault map. For up to two faulty cells it computes and registers the adder's input-select (is0/is1) and output-select (ss0/ss1) controls. Cell 5 is not observable and is treated as healthy.

Parameters:
SETTLE_CYCLES, 1, cycles between driving test_data and sampling actual_output (1..7)
NUM_VEC, 16, number of patterns applied, 0..NUM_VEC-1; fixed at 16 for full coverage

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to run self-test; ignored while busy
actual_output  in  30  adder test observation; bits [6i+5:6i] = cell i, i=0..4
test  out  1  adder test-mode enable
test_data  out  4  pattern to adder
is0, is1  out  3 each  adder input-select controls
ss0, ss1  out  4 each  adder output-select controls
busy  out  1  high from cycle after start accept until done
done  out  1  one-cycle pulse at end of run
fault_map  out  5  bit i = cell i mismatched on at least one pattern
uncorrectable  out  1  last run found an unmappable fault set

Behaviour:
- Reset, synchronous, active-low, also valid mid-run:
  - state IDLE; test=0, test_data=0, busy=0, done=0, fault_map=0, uncorrectable=0.
  - Config set to fault-free default: is0=000, is1=000, ss0=1000, ss1=0000 (logical 0,1,2,3 -> cells 0,1,2,4).
- FSM IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | DECIDE) -> IDLE.
  - IDLE: start=1 -> APPLY; vector counter v=0; working fault register cleared.
  - APPLY (1 cycle): test=1, test_data=v.
  - WAIT: SETTLE_CYCLES-1 further cycles, holding test and test_data.
  - CHECK (1 cycle): compare each 6-bit slice with golden(v); OR the mismatch bits into the working fault register. v==NUM_VEC-1 -> DECIDE, otherwise v++ and go to APPLY.
  - DECIDE (1 cycle): register fault_map and uncorrectable. If correctable, register the new config, otherwise keep the previous config. Pulse done; test=0; go to IDLE.
- test and test_data stay stable from APPLY through CHECK of each pattern. test=0 and test_data=0 in IDLE and DECIDE.
- Latency: done asserts NUM_VEC*(SETTLE_CYCLES+1)+1 cycles after the start cycle (defaults: 33).
- Config outputs change only in DECIDE. They are registered and glitch-free.
- Golden cell response in test mode, input {x1,y1,x0,y0}:
  - Per pair: c1=x^y, c0=~(x|y), s1=~(x^y), s0=x^y.
  - Low pair gives (a1,a0,p1,p0). High pair gives (b1,b0,q1,q0).
  - {c1_1,s1_1} = a1 ? {b1,q1} : {b0,q0}; {c1_0,s1_0} = a0 ? {b1,q1} : {b0,q0}.
  - Response = {c1_1,c1_0,s1_1,s1_0,p1,p0}.
- Mapping, combinational from the fault register:
  - Legal cells per logical position: L0 {0,1,2}, L1 {1,2,3}, L2 {2,3,4}, L3 {4,5}.
  - Greedy: each position takes the lowest healthy legal cell above the previous position's cell.
  - Any position left unassigned -> uncorrectable.
- Input-select encoding (cell hosting logical L):
  - cell1: L0 -> is0[0]=1; L1 -> none.
  - cell2: L0 -> is1[0]=1, is0[0]=1; L1 -> is0[1]=1; L2 -> none.
  - cell3: L1 -> is1[1]=1, is0[1]=1; L2 -> none.
  - cell4: L2 -> is1[2]=1, is0[2]=1; L3 -> none.
  - Bits not set are 0.
- Output-select encoding (position k on cell c):
  - c=k: none.
  - c=k+1: ss0[k]=1.
  - c=k+2: ss1[k]=1, plus ss0[k+1]=1 for k<3.
  - Bits not set are 0.

Decomposition:
- Package csa_bist_pkg: state enum; DEFAULT_IS0/IS1/SS0/SS1; golden_csc(4b)->6b function; legal-cell constants.
- Sub-module csa_reconfig_map: combinational fault_map[4:0] -> {is0, is1, ss0, ss1, uncorrectable}.

Test Plan:
- Reset, then idle 5 cycles -> test=0, busy=0, is0=000, is1=000, ss0=1000, ss1=0000.
- Healthy adder model, start -> test_data steps 0..15; done at cycle 33; fault_map=00000; config stays default. Pattern 0 expects slice 0x26; pattern 5 expects 0x25.
- Cell 1 stuck-at-0 on output bit 5 -> fault_map=00010; is0=010, is1=000, ss0=1110, ss1=0000.
- Cells 0 and 1 faulty -> fault_map=00011; is0=111, is1=111, ss0=1110, ss1=1111.
- Cells 3 and 4 faulty -> ss1=1000, ss0=0000, is0=is1=000. Then cells 2, 3 and 4 faulty -> uncorrectable=1 and the previous config is retained.
- rst_n low at cycle 10 of a run -> next cycle IDLE, test=0, default config, no done pulse. Start while busy -> ignored, done latency unchanged.
